// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: request/response bundle between the two requesters, the arbiter and the result consumer.
interface shift_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op0;
  logic [1:0]  req_op1;
  logic [31:0] req_data0;
  logic [31:0] req_data1;
  logic [4:0]  req_shamt0;
  logic [4:0]  req_shamt1;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_data;
  modport master (
    output req_valid, req_op0, req_op1, req_data0, req_data1, req_shamt0, req_shamt1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data
  );
  modport slave (
    input  req_valid, req_op0, req_op1, req_data0, req_data1, req_shamt0, req_shamt1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin two-port front end for a single right shifter doing SLL/SRL/SRA/PASS.
module shift_arbiter (
  input logic             clock,
  input logic             reset,
  shift_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_PASS} op_e;
  logic        s1_valid_q, s1_valid_d;
  logic        s1_id_q, s1_id_d;
  op_e         s1_op_q, s1_op_d;
  logic [31:0] s1_data_q, s1_data_d;
  logic [4:0]  s1_shamt_q, s1_shamt_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_id, s2_adv, s1_free, accept;
  logic [31:0] sh_in, sh_out, rev_in, rev_out, fill, result;
  always_comb begin
    grant_id = &bus.req_valid ? ~last_grant_q : bus.req_valid[1];
    s2_adv = !resp_valid_q || bus.resp_ready;
    s1_free = !s1_valid_q || s2_adv;
    accept = reset && s1_free && |bus.req_valid;
    // Left shifts reuse the right shifter by mirroring the operand and the result.
    rev_in = {<<{s1_data_q}};
    sh_in = s1_op_q == OP_SLL ? rev_in : s1_data_q;
    sh_out = sh_in >> s1_shamt_q;
    rev_out = {<<{sh_out}};
    fill = ~(32'hFFFF_FFFF >> s1_shamt_q);
    result = s1_op_q == OP_SLL ? rev_out :
             s1_op_q == OP_SRL ? sh_out :
             s1_op_q == OP_SRA ? (sh_out | (s1_data_q[31] ? fill : 32'h0)) : s1_data_q;
    s1_valid_d = accept ? 1'b1 : (s2_adv ? 1'b0 : s1_valid_q);
    s1_id_d = accept ? grant_id : s1_id_q;
    s1_op_d = accept ? op_e'(grant_id ? bus.req_op1 : bus.req_op0) : s1_op_q;
    s1_data_d = accept ? (grant_id ? bus.req_data1 : bus.req_data0) : s1_data_q;
    s1_shamt_d = accept ? (grant_id ? bus.req_shamt1 : bus.req_shamt0) : s1_shamt_q;
    resp_valid_d = s2_adv ? s1_valid_q : resp_valid_q;
    resp_id_d = s2_adv && s1_valid_q ? s1_id_q : resp_id_q;
    resp_data_d = s2_adv && s1_valid_q ? result : resp_data_q;
    last_grant_d = accept ? grant_id : last_grant_q;
  end
  assign bus.req_ready = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id = resp_id_q;
  assign bus.resp_data = resp_data_q;
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_id_q <= 1'b0;
      s1_op_q <= OP_SLL;
      s1_data_q <= 32'h0;
      s1_shamt_q <= 5'h0;
      resp_valid_q <= 1'b0;
      resp_id_q <= 1'b0;
      resp_data_q <= 32'h0;
      last_grant_q <= 1'b1;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q <= s1_id_d;
      s1_op_q <= s1_op_d;
      s1_data_q <= s1_data_d;
      s1_shamt_q <= s1_shamt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q <= resp_id_d;
      resp_data_q <= resp_data_d;
      last_grant_q <= last_grant_d;
    end
  end
endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-requester front end for the shared 32-bit logarithmic right shifter. Arbitrates round-robin between requesters and implements SLL/SRL/SRA on the single right-shift datapath: bit reversal for left shifts, sign fill for arithmetic shifts. Sits between the ALU issue logic (port 0) and the multiply/divide sequencer (port 1). Two-stage pipeline with valid/ready handshakes on both request and response sides.

## Interface
- No parameters; data width fixed at 32, shift amount at 5.
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-low; sampled on the rising edge of clock.
- req_valid  input  2  bit i: requester i presents an operation.
- req_ready  output  2  bit i: requester i's operation is accepted this cycle.
- req_op0, req_op1  input  2 each  00 SLL, 01 SRL, 10 SRA, 11 PASS.
- req_data0, req_data1  input  32 each  operand.
- req_shamt0, req_shamt1  input  5 each  shift amount, 0..31.
- resp_valid  output  1  result register holds a result.
- resp_ready  input  1  consumer takes the result this cycle.
- resp_id  output  1  requester that issued the result.
- resp_data  output  32  shifted result.

## Operation
- Stage S1 register: s1_valid, s1_id, s1_op, s1_data, s1_shamt. Stage S2 is the response register: resp_valid, resp_id, resp_data.
- Arbitration, combinational on the current cycle:
  - One requester valid: that requester is granted.
  - Both valid: the requester not in last_grant is granted.
  - last_grant updates only on an accepted handshake.
- Advance conditions:
  - s2_adv = !resp_valid || resp_ready.
  - s1_free = !s1_valid || s2_adv.
  - req_ready[i] = grant[i] && s1_free && reset high. At most one bit is set per cycle.
  - req_ready may depend combinationally on req_valid. Requesters must hold their inputs stable while valid && !ready.
- Datapath, combinational from S1:
  - SLL: reverse s1_data, right-shift by shamt, reverse the result. Equals data << shamt.
  - SRL: data >> shamt, zero fill.
  - SRA: logical right shift, then force the top shamt bits to data[31]. Equals $signed(data) >>> shamt.
  - PASS: data unchanged, shamt ignored.
  - shamt 0 returns data for every op.
- Registering:
  - On s2_adv, S2 loads s1_valid, s1_id and the datapath result.
  - resp_id and resp_data update only when s1_valid is set.
  - On handshake, S1 loads the granted request. Otherwise, if s2_adv, s1_valid clears.
- Backpressure: while resp_valid && !resp_ready, S2 holds. A valid S1 also holds and req_ready is 0. An empty S1 may accept one request, so there is at most one queued operation.
- Reset values (reset low at an edge): s1_valid 0, resp_valid 0, resp_id 0, resp_data 0, last_grant 1. Port 0 therefore wins the first contention.
- Reset mid-operation: in-flight S1/S2 contents are discarded with no response; req_ready is 0 during reset.

## Timing
- Latency: a request accepted at edge k gives resp_valid=1 after edge k+1, when unstalled.
- Throughput: one operation per cycle under continuous resp_ready=1.
- Back-to-back contention alternates grants 0,1,0,1…
- Simultaneous resp_ready handshake and new request acceptance in the same cycle is legal, with no bubble.
- A response handshake occurs when resp_valid && resp_ready; resp_valid drops the next edge only if S1 was empty.
- Stall release: the cycle after resp_ready returns, S2 takes the S1 result and S1 may accept again in that same cycle.

## Test plan
- **Reset:** hold reset low 2 cycles with req_valid=11 -> req_ready=00, resp_valid=0, resp_data=0. Release, then the first grant goes to port 0.
- **Op coverage, port 0, resp_ready=1:**
  - SLL 0x0000_0001 by 31 -> 0x8000_0000.
  - SRL 0x8000_0000 by 31 -> 0x0000_0001.
  - SRA 0x8000_0000 by 4 -> 0xF800_0000.
  - SRA 0x7FFF_FFFF by 31 -> 0x0000_0000.
  - PASS 0x1234_5678 by 7 -> 0x1234_5678.
  - Each response arrives 2 edges after acceptance with resp_id=0.
- **Contention:** both ports valid continuously, with port 0 SRL 0xF0 by 4 and port 1 SLL 0x0F by 4 -> responses alternate id 0 (0x0F), id 1 (0xF0), … one per cycle.
- **Backpressure:** hold resp_ready=0 for 5 cycles while port 1 streams -> exactly 2 ops accepted, then req_ready=0. resp_data is stable and resp_id=1 throughout. On release, results drain in order with no loss or duplication.
- **Reset mid-flight:** accept 2 ops, assert reset with S1 and S2 full -> both discarded and resp_valid=0. After release, the next op completes normally.
- **Randomized check:** 10k random ops/shamt/valid/ready patterns checked against a reference model (<<, >>, >>>) -> zero mismatches and in-order delivery per requester.
